// File: rtl/recv_cmd_ctrl.sv
// Host command controller for the regex engine: registers host commands, drives
// the code/string BRAM port, sequences engine runs and reports status.
package recv_cmd_axi_pkg;
  localparam int unsigned CMD_NOP                = 0;
  localparam int unsigned CMD_WRITE              = 1;
  localparam int unsigned CMD_READ               = 2;
  localparam int unsigned CMD_START              = 3;
  localparam int unsigned CMD_RESET              = 4;
  localparam int unsigned CMD_READ_ELAPSED_CLOCK = 5;

  localparam int unsigned STATUS_IDLE     = 0;
  localparam int unsigned STATUS_RUNNING  = 1;
  localparam int unsigned STATUS_ACCEPTED = 2;
  localparam int unsigned STATUS_REJECTED = 3;
  localparam int unsigned STATUS_ERROR    = 4;
endpackage

module recv_cmd_ctrl
  import recv_cmd_axi_pkg::*;
#(
  parameter int REG_WIDTH      = 32,
  parameter int MEM_ADDR_WIDTH = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REG_WIDTH-1:0]      data_in_register,
  input  logic [REG_WIDTH-1:0]      address_register,
  input  logic [REG_WIDTH-1:0]      start_cc_pointer_register,
  input  logic [REG_WIDTH-1:0]      end_cc_pointer_register,
  input  logic [REG_WIDTH-1:0]      cmd_register,
  output logic [REG_WIDTH-1:0]      status_register,
  output logic [REG_WIDTH-1:0]      data_o_register,
  output logic                      mem_we,
  output logic                      mem_re,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [REG_WIDTH-1:0]      mem_wdata,
  input  logic [REG_WIDTH-1:0]      mem_rdata,
  output logic                      engine_start,
  output logic                      engine_abort,
  output logic [REG_WIDTH-1:0]      engine_start_ptr,
  output logic [REG_WIDTH-1:0]      engine_end_ptr,
  input  logic                      engine_done,
  input  logic                      engine_accept
);

  // Handshakes: mem_re is a request for the word at mem_addr; mem_rdata is taken
  // exactly one cycle later with no stall. engine_start/engine_abort are 1-cycle
  // pulses; engine_done is a 1-cycle pulse and engine_accept is only meaningful with it.

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RUNNING  = 3'd1,
    ST_DONE_ACC = 3'd2,
    ST_DONE_REJ = 3'd3,
    ST_ERR      = 3'd4
  } state_e;

  state_e state_q, state_d;

  logic [REG_WIDTH-1:0]      data_s1_q, data_s1_d;
  logic [REG_WIDTH-1:0]      addr_s1_q, addr_s1_d;
  logic [REG_WIDTH-1:0]      sptr_s1_q, sptr_s1_d;
  logic [REG_WIDTH-1:0]      eptr_s1_q, eptr_s1_d;
  logic [REG_WIDTH-1:0]      cmd_s1_q, cmd_s1_d;
  logic [REG_WIDTH-1:0]      cmd_prev_q, cmd_prev_d;

  logic [REG_WIDTH-1:0]      status_q, status_d;
  logic                      engine_start_q, engine_start_d;
  logic                      engine_abort_q, engine_abort_d;
  logic [REG_WIDTH-1:0]      start_ptr_q, start_ptr_d;
  logic [REG_WIDTH-1:0]      end_ptr_q, end_ptr_d;

  logic                      mem_we_q, mem_we_d;
  logic [MEM_ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [REG_WIDTH-1:0]      mem_wdata_q, mem_wdata_d;
  logic                      rd_pend_q, rd_pend_d;
  logic                      rd_oor_q, rd_oor_d;
  logic [REG_WIDTH-1:0]      data_o_q, data_o_d;
  logic [REG_WIDTH-1:0]      counter_q, counter_d;

  logic is_write, is_read, is_start, is_reset, is_elapsed;
  logic addr_oor, running, start_rise, start_ok, leave_run, rd_issue;

  function automatic logic [REG_WIDTH-1:0] status_of(input state_e s);
    case (s)
      ST_RUNNING:  status_of = REG_WIDTH'(STATUS_RUNNING);
      ST_DONE_ACC: status_of = REG_WIDTH'(STATUS_ACCEPTED);
      ST_DONE_REJ: status_of = REG_WIDTH'(STATUS_REJECTED);
      ST_ERR:      status_of = REG_WIDTH'(STATUS_ERROR);
      default:     status_of = REG_WIDTH'(STATUS_IDLE);
    endcase
  endfunction

  // Input stage: every decision below looks only at these copies.
  always_comb begin
    data_s1_d  = data_in_register;
    addr_s1_d  = address_register;
    sptr_s1_d  = start_cc_pointer_register;
    eptr_s1_d  = end_cc_pointer_register;
    cmd_s1_d   = cmd_register;
    cmd_prev_d = cmd_s1_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_s1_q  <= '0;
      addr_s1_q  <= '0;
      sptr_s1_q  <= '0;
      eptr_s1_q  <= '0;
      cmd_s1_q   <= '0;
      cmd_prev_q <= '0;
    end else begin
      data_s1_q  <= data_s1_d;
      addr_s1_q  <= addr_s1_d;
      sptr_s1_q  <= sptr_s1_d;
      eptr_s1_q  <= eptr_s1_d;
      cmd_s1_q   <= cmd_s1_d;
      cmd_prev_q <= cmd_prev_d;
    end
  end

  // Command decode; codes outside the table match nothing and behave as NOP.
  always_comb begin
    is_write   = (cmd_s1_q == REG_WIDTH'(CMD_WRITE));
    is_read    = (cmd_s1_q == REG_WIDTH'(CMD_READ));
    is_start   = (cmd_s1_q == REG_WIDTH'(CMD_START));
    is_reset   = (cmd_s1_q == REG_WIDTH'(CMD_RESET));
    is_elapsed = (cmd_s1_q == REG_WIDTH'(CMD_READ_ELAPSED_CLOCK));
    addr_oor   = ((addr_s1_q >> MEM_ADDR_WIDTH) != '0);
    running    = (state_q == ST_RUNNING);
    start_rise = is_start && (cmd_prev_q != REG_WIDTH'(CMD_START));
    start_ok   = (state_q == ST_IDLE) && start_rise && (sptr_s1_q <= eptr_s1_q);
    leave_run  = running && (is_reset || engine_done);
    rd_issue   = is_read && !running;
  end

  // FSM process 1: state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // FSM process 2: next state. A host reset outranks a same-cycle engine_done.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_rise) state_d = (sptr_s1_q <= eptr_s1_q) ? ST_RUNNING : ST_ERR;
      end
      ST_RUNNING: begin
        if (is_reset)         state_d = ST_IDLE;
        else if (engine_done) state_d = engine_accept ? ST_DONE_ACC : ST_DONE_REJ;
      end
      default: begin
        if (is_reset) state_d = ST_IDLE;
      end
    endcase
  end

  // FSM process 3: registered outputs derived from the transition.
  always_comb begin
    status_d       = status_of(state_d);
    engine_start_d = start_ok;
    engine_abort_d = running && is_reset;
    start_ptr_d    = start_ok ? sptr_s1_q : start_ptr_q;
    end_ptr_d      = start_ok ? eptr_s1_q : end_ptr_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      status_q       <= '0;
      engine_start_q <= 1'b0;
      engine_abort_q <= 1'b0;
      start_ptr_q    <= '0;
      end_ptr_q      <= '0;
    end else begin
      status_q       <= status_d;
      engine_start_q <= engine_start_d;
      engine_abort_q <= engine_abort_d;
      start_ptr_q    <= start_ptr_d;
      end_ptr_q      <= end_ptr_d;
    end
  end

  // Host datapath: BRAM writes, read return, elapsed counter.
  always_comb begin
    mem_we_d    = is_write && !running && !addr_oor;
    mem_addr_d  = mem_we_d ? addr_s1_q[MEM_ADDR_WIDTH-1:0] : mem_addr_q;
    mem_wdata_d = mem_we_d ? data_s1_q : mem_wdata_q;
    rd_pend_d   = rd_issue;
    rd_oor_d    = addr_oor;

    data_o_d = data_o_q;
    if (rd_pend_q)  data_o_d = rd_oor_q ? '0 : mem_rdata;
    if (is_elapsed) data_o_d = counter_q;

    counter_d = counter_q;
    if (start_ok) counter_d = '0;
    else if (running && !leave_run && (counter_q != '1)) counter_d = counter_q + REG_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rd_pend_q   <= 1'b0;
      rd_oor_q    <= 1'b0;
      data_o_q    <= '0;
      counter_q   <= '0;
    end else begin
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rd_pend_q   <= rd_pend_d;
      rd_oor_q    <= rd_oor_d;
      data_o_q    <= data_o_d;
      counter_q   <= counter_d;
    end
  end

  // Reads are issued straight from the input stage so data lands two edges after S1.
  assign mem_re           = rd_issue && !addr_oor;
  assign mem_addr         = mem_re ? addr_s1_q[MEM_ADDR_WIDTH-1:0] : mem_addr_q;
  assign mem_we           = mem_we_q;
  assign mem_wdata        = mem_wdata_q;
  assign status_register  = status_q;
  assign data_o_register  = data_o_q;
  assign engine_start     = engine_start_q;
  assign engine_abort     = engine_abort_q;
  assign engine_start_ptr = start_ptr_q;
  assign engine_end_ptr   = end_ptr_q;

endmodule
